// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates conditional branches, checks the IF prediction,
// trains a 2-bit saturating BHT and issues registered redirect/flush pulses.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_rd0,
    input  logic [XLEN-1:0]  ex_rd1,
    input  logic [2:0]       ex_br_type,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             cnt_clr,
    output logic             br_taken,
    output logic             mispredict,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [2:0] {
        BR_NONE0 = 3'd0,
        BR_EQ    = 3'd1,
        BR_NE    = 3'd2,
        BR_LT    = 3'd3,
        BR_GE    = 3'd4,
        BR_LTU   = 3'd5,
        BR_GEU   = 3'd6,
        BR_NONE7 = 3'd7
    } br_type_t;

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             is_branch;
    logic             resolve;
    logic             taken;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             miss;
    logic [1:0]       cur_ctr;
    logic [1:0]       next_ctr;
    logic [XLEN-1:0]  next_pc;
    logic             unused_if_pc;

    assign if_idx       = if_pc[IDX_W+1:2];
    assign ex_idx       = ex_pc[IDX_W+1:2];
    assign unused_if_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // Read-before-write: the lookup sees the table as it stands before this edge.
    assign if_pred_taken = bht[if_idx][1];

    assign eq  = (ex_rd0 == ex_rd1);
    assign lt  = ($signed(ex_rd0) < $signed(ex_rd1));
    assign ltu = (ex_rd0 < ex_rd1);

    always_comb begin
        taken     = 1'b0;
        is_branch = 1'b1;
        case (br_type_t'(ex_br_type))
            BR_EQ:   taken = eq;
            BR_NE:   taken = !eq;
            BR_LT:   taken = lt;
            BR_GE:   taken = !lt;
            BR_LTU:  taken = ltu;
            BR_GEU:  taken = !ltu;
            default: is_branch = 1'b0;
        endcase
    end

    // A flush in progress marks the current EX instruction as wrong-path.
    assign resolve = ex_valid && !ex_stall && is_branch && !flush;
    assign miss    = (taken != ex_pred_taken);
    assign next_pc = taken ? ex_target : (ex_pc + XLEN'(4));

    assign cur_ctr = bht[ex_idx];

    always_comb begin
        next_ctr = cur_ctr;
        if (taken) begin
            if (cur_ctr != 2'd3) next_ctr = cur_ctr + 2'd1;
        end else begin
            if (cur_ctr != 2'd0) next_ctr = cur_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'd1;
        end else if (resolve) begin
            bht[ex_idx] <= next_ctr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_taken    <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            br_taken    <= resolve && taken;
            mispredict  <= resolve && miss;
            redirect_pc <= resolve ? next_pc : '0;
        end
    end

    assign flush = mispredict;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (cnt_clr) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (resolve) begin
            if (br_count != '1) br_count <= br_count + CNT_W'(1);
            if (miss && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule
